// File: rtl/mult_div_unit_if.sv
// Operand/strobe/result bundle between the issuing stage and the multiply/divide unit.
interface mult_div_unit_if;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed 32-bit multiply (shift-add) and divide (restoring), one bit per cycle.
// Both operate on magnitudes and fix the sign in a final cycle that also loads the result.
module mult_div_unit (
  input  logic            clock,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state, state_nx;
  logic [4:0]  cnt;
  logic        fin;
  logic [63:0] acc;   // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
  logic [31:0] opb;
  logic        neg;
  logic [31:0] res_q;
  logic        exc_q, rdy_q;

  logic        start;
  logic [31:0] amag, bmag;
  logic [32:0] sum;
  logic [63:0] mul_nx, div_nx, prod;
  logic [31:0] r, rem_nx, quo, qs;
  logic [32:0] diff;
  logic        ge, mul_exc, div_exc;

  assign start = bus.ctrl_MULT | bus.ctrl_DIV;
  assign amag  = bus.data_operandA[31] ? (~bus.data_operandA + 32'd1) : bus.data_operandA;
  assign bmag  = bus.data_operandB[31] ? (~bus.data_operandB + 32'd1) : bus.data_operandB;

  // Shift-add step: conditionally add multiplicand into the high half, then shift right.
  assign sum    = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
  assign mul_nx = {sum, acc[31:1]};

  // Restoring step: remainder stays below the divisor, so 32 bits suffice when divisor != 0.
  assign r      = {acc[62:32], acc[31]};
  assign diff   = {1'b0, r} - {1'b0, opb};
  assign ge     = ~diff[32];
  assign rem_nx = ge ? diff[31:0] : r;
  assign div_nx = {rem_nx, acc[30:0], ge};

  assign prod    = neg ? (~acc + 64'd1) : acc;
  assign mul_exc = prod[63:32] != {32{prod[31]}};
  assign quo     = acc[31:0];
  assign qs      = neg ? (~quo + 32'd1) : quo;
  // Only |A|=2^31 with a non-negative quotient sign can produce an unrepresentable quotient.
  assign div_exc = (opb == 32'd0) | (quo[31] & ~neg);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (start) state_nx = bus.ctrl_MULT ? MUL : DIV;
    else begin
      case (state)
        MUL, DIV: if (fin) state_nx = DONE;
        DONE:     state_nx = IDLE;
        default:  state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0; fin <= 1'b0; acc <= '0; opb <= '0; neg <= 1'b0;
      res_q <= '0; exc_q <= 1'b0; rdy_q <= 1'b0;
    end else if (start) begin
      cnt   <= '0;
      fin   <= 1'b0;
      acc   <= {32'd0, amag};
      opb   <= bmag;
      neg   <= bus.data_operandA[31] ^ bus.data_operandB[31];
      res_q <= '0;
      exc_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      case (state)
        MUL, DIV: begin
          if (fin) begin
            res_q <= (state == MUL) ? prod[31:0] : ((opb == 32'd0) ? 32'd0 : qs);
            exc_q <= (state == MUL) ? mul_exc : div_exc;
            rdy_q <= 1'b1;
          end else begin
            acc <= (state == MUL) ? mul_nx : div_nx;
            cnt <= cnt + 5'd1;
            fin <= (cnt == 5'd31);
          end
        end
        default: rdy_q <= 1'b0;
      endcase
    end
  end

  assign bus.data_result    = res_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: fixed vectors, random ops against a longint model, and abort/reset sequences.
module tb_mult_div_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mult_div_unit_if bus();
  mult_div_unit dut (.clock(clock), .reset(reset), .bus(bus));

  int ntot = 0;
  int npass = 0;

  typedef struct {
    bit          m;
    bit          d;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    bit          exc;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference: plain 64-bit signed arithmetic.
  task automatic model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output bit e);
    longint p, q;
    if (!is_div) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = q[31:0];
      e = (q > 64'sd2147483647);
    end
  endtask

  // Strobe held for 'hold' edges; a/b are presented on the last strobe edge only.
  task automatic do_op(input string nm, input bit m, input bit d, input logic [31:0] a,
                       input logic [31:0] b, input int hold, input logic [31:0] er, input bit ee);
    int lat;
    logic [31:0] res;
    logic exc;
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      bus.ctrl_MULT = m; bus.ctrl_DIV = d;
      if (h == hold - 1) begin bus.data_operandA = a; bus.data_operandB = b; end
      else begin bus.data_operandA = $urandom; bus.data_operandB = $urandom; end
    end
    @(negedge clock);
    bus.ctrl_MULT = 1'b0; bus.ctrl_DIV = 1'b0;
    bus.data_operandA = $urandom; bus.data_operandB = $urandom;
    chk({nm, " start_clear"}, {31'd0, bus.data_resultRDY, bus.data_exception, bus.data_result}, 64'd0);
    lat = -1; res = 'x; exc = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (bus.data_resultRDY) begin lat = k; res = bus.data_result; exc = bus.data_exception; break; end
    end
    chk({nm, " latency"}, 64'(lat), 64'd33);
    chk({nm, " result"}, {32'd0, res}, {32'd0, er});
    chk({nm, " exception"}, {63'd0, exc}, {63'd0, ee});
    @(negedge clock);
    chk({nm, " rdy_pulse_hold"}, {31'd0, bus.data_resultRDY, bus.data_exception, bus.data_result},
        {31'd0, 1'b0, ee, er});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      3: return 32'($signed($urandom_range(0, 2000)) - 1000);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ra, rb, er, r3;
    bit m, d, ee;
    int pulses, first;

    vt[0] = '{1, 0, 32'd6,          32'd5,          32'd30,         0};
    vt[0] = '{1, 0, 32'd6,          32'd7,          32'h0000_002A,  0};
    vt[1] = '{1, 0, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  0};
    vt[2] = '{1, 0, 32'h0001_0000,  32'h0001_0000,  32'h0000_0000,  1};
    vt[3] = '{1, 0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vt[4] = '{0, 1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  0};
    vt[5] = '{0, 1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'h0000_000E,  0};
    vt[6] = '{0, 1, 32'd5,          32'd0,          32'h0000_0000,  1};
    vt[7] = '{0, 1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vt[8] = '{1, 1, 32'd7,          32'd3,          32'd21,         0};
    vt[9] = '{0, 1, 32'h8000_0000,  32'd1,          32'h8000_0000,  0};

    bus.ctrl_MULT = 1'b0; bus.ctrl_DIV = 1'b0;
    bus.data_operandA = 32'd0; bus.data_operandB = 32'd0;
    repeat (2) @(negedge clock);
    chk("reset_state", {31'd0, bus.data_resultRDY, bus.data_exception, bus.data_result}, 64'd0);
    reset = 1'b0;

    foreach (vt[i])
      do_op($sformatf("vec%0d", i), vt[i].m, vt[i].d, vt[i].a, vt[i].b, 1, vt[i].res, vt[i].exc);

    // Held strobe: restarts each cycle, final operands count.
    do_op("held_mul", 1, 0, 32'hFFFF_FFF6, 32'd12, 5, 32'hFFFF_FF88, 0);
    do_op("held_div", 0, 1, 32'd1000, 32'd7, 3, 32'd142, 0);

    // Abort MULT with DIV at E10: single RDY 33 edges after the DIV strobe.
    @(negedge clock);
    bus.ctrl_MULT = 1'b1; bus.data_operandA = 32'd3; bus.data_operandB = 32'd4;
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
    repeat (9) @(negedge clock);
    bus.ctrl_DIV = 1'b1; bus.data_operandA = 32'd9; bus.data_operandB = 32'd3;
    @(negedge clock);
    bus.ctrl_DIV = 1'b0;
    pulses = 0; first = -1; r3 = 'x;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clock);
      if (bus.data_resultRDY) begin
        pulses++;
        if (first < 0) begin first = k; r3 = bus.data_result; end
      end
    end
    chk("abort_pulses", 64'(pulses), 64'd1);
    chk("abort_latency", 64'(first), 64'd33);
    chk("abort_result", {32'd0, r3}, 64'd3);

    // Reset mid-divide at E15: outputs cleared and no RDY through E50.
    do_op("pre_reset", 1, 0, 32'd9, 32'd9, 1, 32'd81, 0);
    @(negedge clock);
    bus.ctrl_DIV = 1'b1; bus.data_operandA = 32'd1000; bus.data_operandB = 32'd7;
    @(negedge clock);
    bus.ctrl_DIV = 1'b0;
    repeat (14) @(negedge clock);
    reset = 1'b1;
    bus.ctrl_MULT = 1'b1;
    @(negedge clock);
    reset = 1'b0; bus.ctrl_MULT = 1'b0;
    chk("reset_clear", {31'd0, bus.data_resultRDY, bus.data_exception, bus.data_result}, 64'd0);
    pulses = 0;
    for (int k = 16; k <= 50; k++) begin
      @(negedge clock);
      if (bus.data_resultRDY) pulses++;
    end
    chk("reset_no_rdy", 64'(pulses), 64'd0);
    do_op("post_reset", 1, 0, 32'd2, 32'd2, 1, 32'd4, 0);

    for (int i = 0; i < 40; i++) begin
      m = $urandom_range(0, 1);
      d = m ? ($urandom_range(0, 3) == 0) : 1'b1;
      ra = pick(); rb = pick();
      model(!m, ra, rb, er, ee);
      do_op($sformatf("rnd%0d", i), m, d, ra, rb, 1, er, ee);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: none; datapath width SHALL be fixed at 32 bits, two's-complement signed.
REQ-002 clock  input  1  single system clock; all state SHALL update on its rising edge only.
REQ-003 reset  input  1  reset is synchronous and active-high, sampled on the rising edge of clock.
REQ-004 ctrl_MULT  input  1  start-multiply strobe, one cycle.
REQ-005 ctrl_DIV  input  1  start-divide strobe, one cycle.
REQ-006 data_operandA  input  32  multiplicand / dividend, sampled only on the start edge.
REQ-007 data_operandB  input  32  multiplier / divisor, sampled only on the start edge.
REQ-008 data_result  output  32  product low word or quotient; registered.
REQ-009 data_exception  output  1  overflow or divide-by-zero flag; registered.
REQ-010 data_resultRDY  output  1  one-cycle completion pulse; writeback SHALL use it as the write enable of the 32-bit destination register.

Function
REQ-011 States SHALL be IDLE, MUL, DIV and DONE; each operation SHALL be iterative at one bit per cycle, with no combinational 32x32 multiplier or divider.
REQ-012 Start edge E0: ctrl_MULT or ctrl_DIV high at a rising edge SHALL latch both operands and enter MUL or DIV.
REQ-013 The iteration counter SHALL run 0..31, 32 cycles total.
REQ-014 A start edge SHALL clear data_result, data_exception and data_resultRDY to 0.
REQ-015 Latency: results SHALL be loaded and data_resultRDY set at edge E33.
REQ-016 data_resultRDY SHALL be cleared at E34; the state SHALL then go DONE->IDLE.
REQ-017 data_resultRDY SHALL be high for exactly one cycle per completed operation and never otherwise.
REQ-018 data_result and data_exception SHALL hold their values from E33 until the next start edge or reset.
REQ-019 Multiply: data_result SHALL equal the low 32 bits of the signed 64-bit product A*B.
REQ-020 Multiply: data_exception SHALL be 1 iff the product does not fit in signed 32 bits, i.e. the high word is not the sign-extension of bit 31.
REQ-021 Divide: data_result SHALL equal the signed quotient A/B truncated toward zero; the remainder SHALL be discarded.
REQ-022 Divide-by-zero (B=0): data_result SHALL be 0x00000000 and data_exception SHALL be 1, with the same 33-cycle latency.
REQ-023 Divide overflow (A=0x80000000, B=0xFFFFFFFF): data_result SHALL be 0x80000000 and data_exception SHALL be 1.
REQ-024 Signed divide SHALL use magnitudes internally, with the quotient negated when the operand signs differ.
REQ-025 Simultaneous ctrl_MULT and ctrl_DIV: multiply SHALL win and divide SHALL be ignored.
REQ-026 A start strobe in MUL, DIV or DONE SHALL abort the current operation without any RDY pulse for it, re-latch the operands, and restart at E0 semantics.
REQ-027 Operand input changes after the start edge SHALL have no effect on the result.
REQ-028 Strobes held high for several cycles SHALL restart the operation every cycle; completion SHALL come 33 edges after the last strobe edge.

Reset
REQ-029 Reset high at a rising edge SHALL force IDLE, data_result=0, data_exception=0, data_resultRDY=0 and the counter to 0, in any state.
REQ-030 Reset SHALL take priority over ctrl_MULT and ctrl_DIV on the same edge.
REQ-031 An operation in progress at reset SHALL be discarded and SHALL produce no RDY pulse.
REQ-032 After reset deasserts, the block SHALL accept a start on the next edge.

Verification
REQ-033 MULT with A=6, B=7 -> RDY exactly at E33, result 0x0000002A, exception 0; A=-3, B=5 -> result 0xFFFFFFF1, exception 0.
REQ-034 MULT with A=0x00010000, B=0x00010000 -> result 0x00000000, exception 1; A=0x80000000, B=0xFFFFFFFF -> result 0x80000000, exception 1.
REQ-035 DIV with A=100, B=-7 -> result 0xFFFFFFF2, exception 0; A=-100, B=-7 -> result 0x0000000E, exception 0.
REQ-036 DIV with A=5, B=0 -> result 0, exception 1 at E33; DIV with A=0x80000000, B=0xFFFFFFFF -> result 0x80000000, exception 1.
REQ-037 Start MULT 3*4, then DIV 9/3 at E10 -> no RDY at the original E33; a single RDY 33 edges after the DIV strobe with result 3.
REQ-038 Start DIV, assert reset at E15 -> all outputs 0 at E16 and no RDY through E50; a new MULT 2*2 after reset -> result 4 at its E33.
